// File: rtl/mult8_compare_unit.sv
// Registered 8x8 unsigned multiplier comparison unit: exact Wallace tree, exact
// carry-save array, and fully approximate Wallace tree, plus a mismatch flag and the approximation error.
module mult8_compare_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [7:0]  A,
  input  logic [7:0]  B,
  output logic        out_valid,
  output logic [15:0] S_exact,
  output logic [15:0] S_array,
  output logic [15:0] S_approx,
  output logic        mismatch,
  output logic [15:0] err
);

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  function automatic logic [15:0] ripple_add(input logic [15:0] x, input logic [15:0] y);
    logic [15:0] s;
    logic        c;
    c = 1'b0;
    for (int k = 0; k < 16; k++) begin
      s[k] = x[k] ^ y[k] ^ c;
      c    = maj3(x[k], y[k], c);
    end
    return s;
  endfunction

  // Rows carry an occupancy mask alongside their bits: adder selection follows
  // which positions structurally hold a bit, not the bit values.
  function automatic logic [15:0] wallace_mult(input logic [7:0] a, input logic [7:0] b,
                                               input logic approx);
    logic [15:0] row  [8];
    logic [15:0] msk  [8];
    logic [15:0] nrow [8];
    logic [15:0] nmsk [8];
    logic [15:0] s, c, sm, cm;
    logic [2:0]  x, p;
    int          n, ng;
    for (int i = 0; i < 8; i++) begin
      row[i] = 16'({8{b[i]}} & a) << i;
      msk[i] = 16'h00ff << i;
    end
    n = 8;
    // Four layers take the row count 8 -> 6 -> 4 -> 3 -> 2.
    for (int layer = 0; layer < 4; layer++) begin
      ng = n / 3;
      for (int r = 0; r < 8; r++) begin
        nrow[r] = '0;
        nmsk[r] = '0;
      end
      for (int g = 0; g < 2; g++) begin
        if (g < ng) begin
          s  = '0;
          c  = '0;
          sm = '0;
          cm = '0;
          for (int col = 0; col < 16; col++) begin
            p = {msk[3*g+2][col], msk[3*g+1][col], msk[3*g][col]};
            x = {row[3*g+2][col], row[3*g+1][col], row[3*g][col]} & p;
            // With absent inputs tied low, XOR/majority cover full adder, half adder and pass-through alike.
            s[col]  = (approx && (&p)) ? |x : ^x;
            sm[col] = |p;
            if (col < 15) begin
              c[col+1]  = maj3(x[0], x[1], x[2]);
              cm[col+1] = maj3(p[0], p[1], p[2]);
            end
          end
          nrow[2*g]   = s;
          nmsk[2*g]   = sm;
          nrow[2*g+1] = c;
          nmsk[2*g+1] = cm;
        end
      end
      for (int r = 0; r < 8; r++) begin
        if (r >= 3 * ng && r < n) begin
          nrow[r-ng] = row[r];
          nmsk[r-ng] = msk[r];
        end
      end
      row = nrow;
      msk = nmsk;
      n   = n - ng;
    end
    return ripple_add(row[0], row[1]);
  endfunction

  function automatic logic [15:0] array_mult(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] s, c, p, t;
    s = 16'({8{b[0]}} & a);
    c = '0;
    for (int i = 1; i < 8; i++) begin
      p = 16'({8{b[i]}} & a) << i;
      t = s ^ c ^ p;
      c = ((s & c) | (s & p) | (c & p)) << 1;
      s = t;
    end
    return ripple_add(s, c);
  endfunction

  logic [15:0] exact_c, array_c, approx_c;

  always_comb begin
    exact_c  = wallace_mult(A, B, 1'b0);
    approx_c = wallace_mult(A, B, 1'b1);
    array_c  = array_mult(A, B);
  end

  // NOTE: registers use non-blocking assignments so every output samples the
  // pre-edge combinational values together; reset is asynchronous so outputs clear without a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      S_exact   <= '0;
      S_array   <= '0;
      S_approx  <= '0;
      mismatch  <= 1'b0;
      err       <= '0;
    end else begin
      out_valid <= in_valid;
      S_exact   <= exact_c;
      S_array   <= array_c;
      S_approx  <= approx_c;
      mismatch  <= (exact_c != array_c);
      err       <= approx_c - exact_c;
    end
  end

endmodule

// File: tb/tb_mult8_compare_unit.sv
// Scoreboard bench for mult8_compare_unit: reset, corners, exhaustive sweep
// against an independent row/column model of the approximate tree, and random streaming.
module tb_mult8_compare_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  A, B;
  logic        out_valid;
  logic [15:0] S_exact, S_array, S_approx, err;
  logic        mismatch;

  mult8_compare_unit dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .A(A), .B(B),
    .out_valid(out_valid), .S_exact(S_exact), .S_array(S_array),
    .S_approx(S_approx), .mismatch(mismatch), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [15:0] ex;
    logic [15:0] ap;
    longint      ap_full;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Bit-per-position model: -1 marks an empty position, rows keep unbounded width.
  function automatic longint model_approx(input logic [7:0] a, input logic [7:0] b);
    int     bv [8][24];
    int     nb [8][24];
    int     n, ng, cnt, ones;
    longint total;
    for (int r = 0; r < 8; r++)
      for (int col = 0; col < 24; col++) bv[r][col] = -1;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) bv[i][i+j] = int'(a[j] & b[i]);
    n = 8;
    while (n > 2) begin
      ng = n / 3;
      for (int r = 0; r < 8; r++)
        for (int col = 0; col < 24; col++) nb[r][col] = -1;
      for (int g = 0; g < ng; g++) begin
        for (int col = 0; col < 23; col++) begin
          cnt  = 0;
          ones = 0;
          for (int k = 0; k < 3; k++) begin
            if (bv[3*g+k][col] >= 0) begin
              cnt++;
              ones += bv[3*g+k][col];
            end
          end
          if (cnt == 1) begin
            nb[2*g][col] = ones;
          end else if (cnt == 2) begin
            nb[2*g][col]     = ones % 2;
            nb[2*g+1][col+1] = ones / 2;
          end else if (cnt == 3) begin
            nb[2*g][col]     = (ones > 0) ? 1 : 0;
            nb[2*g+1][col+1] = (ones >= 2) ? 1 : 0;
          end
        end
      end
      for (int r = 3 * ng; r < n; r++)
        for (int col = 0; col < 24; col++) nb[r-ng][col] = bv[r][col];
      bv = nb;
      n  = n - ng;
    end
    total = 0;
    for (int r = 0; r < 2; r++)
      for (int col = 0; col < 24; col++)
        if (bv[r][col] > 0) total += longint'(1) << col;
    return total;
  endfunction

  task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic v);
    exp_t e;
    A        = a;
    B        = b;
    in_valid = v;
    e.v       = v;
    e.ex      = 16'(int'(a) * int'(b));
    e.ap_full = model_approx(a, b);
    e.ap      = e.ap_full[15:0];
    sb.push_back(e);
  endtask

  task automatic step_check();
    exp_t e;
    @(posedge clk);
    #1;
    check("sb_depth", 32'(sb.size()), 32'd1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    check("out_valid", 32'(out_valid), 32'(e.v));
    check("S_exact",   32'(S_exact),   32'(e.ex));
    check("S_array",   32'(S_array),   32'(e.ex));
    check("mismatch",  32'(mismatch),  32'd0);
    check("S_approx",  32'(S_approx),  32'(e.ap));
    check("err",       32'(err),       32'(16'(e.ap - e.ex)));
    if (e.ap_full < 65536) check("approx_ge", 32'(S_approx >= S_exact), 32'd1);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_S_exact"},   32'(S_exact),   32'd0);
    check({tag, "_S_array"},   32'(S_array),   32'd0);
    check({tag, "_S_approx"},  32'(S_approx),  32'd0);
    check({tag, "_mismatch"},  32'(mismatch),  32'd0);
    check({tag, "_err"},       32'(err),       32'd0);
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b1;
    A        = 8'd7;
    B        = 8'd9;
    #2;
    check_cleared("rst_initial");
    @(posedge clk);
    #1;
    check_cleared("rst_clocked");
    #2;
    rst_n = 1'b1;

    // Mid-stream reset: a loaded result must vanish without waiting for a clock edge.
    drive(8'd10, 8'd20, 1'b1);
    @(posedge clk);
    #1;
    check("pre_reset_exact", 32'(S_exact), 32'd200);
    sb.delete();
    rst_n = 1'b0;
    #1;
    check_cleared("rst_midstream");
    @(posedge clk);
    #1;
    check_cleared("rst_held");
    #2;
    rst_n = 1'b1;

    drive(8'd3, 8'd5, 1'b1);
    step_check();
    check("first_3x5", 32'(S_exact), 32'd15);

    drive(8'd255, 8'd255, 1'b1);
    step_check();
    check("max_array", 32'(S_array), 32'd65025);

    drive(8'd0, 8'd200, 1'b1);
    step_check();
    check("zero_approx", 32'(S_approx), 32'd0);

    drive(8'd173, 8'd1, 1'b1);
    step_check();
    check("approx_173", 32'(S_approx), 32'd173);
    check("err_173",    32'(err),      32'd0);

    for (int b = 0; b < 256; b++)
      for (int a = 0; a < 256; a++) begin
        drive(8'(a), 8'(b), 1'b1);
        step_check();
      end

    for (int i = 0; i < 2000; i++) begin
      drive(8'($urandom_range(255)), 8'($urandom_range(255)), 1'($urandom_range(1)));
      step_check();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
